// File: rtl/ureg_arbiter_if.sv
// Bus bundle between the two register requesters, the arbiter and the user register bank.
// Signal names follow the register-port naming used by the surrounding design.
interface ureg_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshake: a requester holds mX_req high (with write/addr/wdata stable) until it
  // sees the one-cycle mX_gnt pulse, then drops req the following cycle; a req still
  // high once the arbiter is idle again is a new access. Read data comes back later
  // as a one-cycle mX_rvalid pulse with mX_rdata. There is no backpressure from the bank.
  logic          m0_req;
  logic          m0_write;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_write;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          s_write;
  logic          s_read;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          busy;

  modport slave (
    input  m0_req, m0_write, m0_addr, m0_wdata,
    input  m1_req, m1_write, m1_addr, m1_wdata,
    input  s_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output s_write, s_read, s_addr, s_wdata, busy
  );

  modport master (
    output m0_req, m0_write, m0_addr, m0_wdata,
    output m1_req, m1_write, m1_addr, m1_wdata,
    output s_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  s_write, s_read, s_addr, s_wdata, busy
  );
endinterface

// File: rtl/ureg_arbiter.sv
// Round-robin arbiter sharing one user register bank port between the AHB slave path (m0)
// and a local master (m1); serialises accesses and returns read data after RD_LAT cycles.
module ureg_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  ureg_arbiter_if.slave      bus,
  output logic [1:0]         o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RD_WAIT = 2'd2,
    S_RD_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_prio;   // 0: m0 holds priority, 1: m1 holds priority
  logic          r_win;
  logic          r_wr;
  logic [3:0]    r_cnt;
  logic          r_m0_gnt;
  logic          r_m1_gnt;
  logic          r_m0_rvalid;
  logic          r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          r_s_write;
  logic          r_s_read;
  logic [AW-1:0] r_s_addr;
  logic [DW-1:0] r_s_wdata;
  logic          r_busy;

  logic          w_any;
  logic          w_win;
  logic          w_sel_write;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_any       = bus.m0_req | bus.m1_req;
    // Priority holder wins if requesting, otherwise the other side.
    w_win       = r_prio ? bus.m1_req : !bus.m0_req;
    w_sel_write = w_win ? bus.m1_write : bus.m0_write;
    w_sel_addr  = w_win ? bus.m1_addr  : bus.m0_addr;
    w_sel_wdata = w_win ? bus.m1_wdata : bus.m0_wdata;
    w_next      = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_next = S_ACCESS;
      S_ACCESS:  w_next = r_wr ? S_IDLE : S_RD_WAIT;
      S_RD_WAIT: if (r_cnt == 4'd0) w_next = S_RD_DONE;
      S_RD_DONE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prio      <= 1'b0;
      r_win       <= 1'b0;
      r_wr        <= 1'b0;
      r_cnt       <= 4'd0;
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_s_write   <= 1'b0;
      r_s_read    <= 1'b0;
      r_s_addr    <= '0;
      r_s_wdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_m0_gnt    <= 1'b0;
      r_m1_gnt    <= 1'b0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_s_write   <= 1'b0;
      r_s_read    <= 1'b0;
      r_busy      <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win     <= w_win;
            r_wr      <= w_sel_write;
            r_s_addr  <= w_sel_addr;
            r_s_wdata <= w_sel_wdata;
            r_s_write <= w_sel_write;
            r_s_read  <= !w_sel_write;
            r_m0_gnt  <= !w_win;
            r_m1_gnt  <= w_win;
            r_prio    <= !w_win;
          end
        end
        S_ACCESS: begin
          if (!r_wr) r_cnt <= LAT_M1;
        end
        S_RD_WAIT: begin
          if (r_cnt == 4'd0) begin
            // Only the winner's rdata moves; the other side keeps its last value.
            if (r_win) begin
              r_m1_rdata  <= bus.s_rdata;
              r_m1_rvalid <= 1'b1;
            end else begin
              r_m0_rdata  <= bus.s_rdata;
              r_m0_rvalid <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m0_gnt    = r_m0_gnt;
  assign bus.m1_gnt    = r_m1_gnt;
  assign bus.m0_rvalid = r_m0_rvalid;
  assign bus.m1_rvalid = r_m1_rvalid;
  assign bus.m0_rdata  = r_m0_rdata;
  assign bus.m1_rdata  = r_m1_rdata;
  assign bus.s_write   = r_s_write;
  assign bus.s_read    = r_s_read;
  assign bus.s_addr    = r_s_addr;
  assign bus.s_wdata   = r_s_wdata;
  assign bus.busy      = r_busy;
  assign o_dbg_state   = r_state;

endmodule
